// File: rtl/sync_fifo_level.sv
// sync_fifo_level: single-clock FIFO with registered count/level flags, flush and sticky overflow/underflow; ports clk, rst_n, flush, wr_en/din, rd_en/dout, clr_err, count, full/empty/almost_full/almost_empty, overflow/underflow; define FIFO_FWFT_EN for first-word-fall-through dout
module sync_fifo_level #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_L = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, count_nxt;
  logic wa, ra, unused_ptr_msb;
  assign wa = wr_en & ~full & ~flush;
  assign ra = rd_en & ~empty & ~flush;
  assign unused_ptr_msb = wr_ptr[ADDR_WIDTH] ^ rd_ptr[ADDR_WIDTH];
  always_comb begin
    count_nxt = flush ? '0 : count + (ADDR_WIDTH+1)'(wa) - (ADDR_WIDTH+1)'(ra);
  end
  always_ff @(posedge clk) begin
    if (wa) mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= flush ? '0 : wr_ptr + (ADDR_WIDTH+1)'(wa);
      rd_ptr       <= flush ? '0 : rd_ptr + (ADDR_WIDTH+1)'(ra);
      count        <= count_nxt;
      full         <= count_nxt == DEPTH_L;
      empty        <= count_nxt == '0;
      almost_full  <= count_nxt >= AF_L;
      almost_empty <= count_nxt <= AE_L;
      overflow     <= (wr_en & full & ~flush) | (overflow & ~clr_err);
      underflow    <= (rd_en & empty & ~flush) | (underflow & ~clr_err);
    end
  end
`ifdef FIFO_FWFT_EN
  assign dout = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else if (ra) dout <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end
`endif
endmodule
